// File: rtl/run_sequencer_if.sv
// Host/core handshake bundle for run_sequencer.
//   req        : level start request (host -> sequencer)
//   prog_ctr   : current core program counter (core -> sequencer)
//   core_reset : reset to the core datapath
//   core_run   : enable for core PC and register writes
//   busy       : run in progress
//   done       : run finished by halt or by fault
//   timeout    : run ended by cycle-budget exhaustion
//   cycle_cnt  : RUN cycles consumed by the current or most recent run
interface run_sequencer_if #(
   parameter int unsigned PW = 9
);
   logic          req;
   logic [PW-1:0] prog_ctr;
   logic          core_reset;
   logic          core_run;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [15:0]   cycle_cnt;

   // Host / testbench side
   modport master (
      output req, prog_ctr,
      input  core_reset, core_run, busy, done, timeout, cycle_cnt
   );

   // Sequencer side
   modport slave (
      input  req, prog_ctr,
      output core_reset, core_run, busy, done, timeout, cycle_cnt
   );
endinterface

// File: rtl/run_sequencer.sv
// Run sequencer: resets a core for RST_CYC cycles on a start request, lets it
// run until its PC reaches HALT_ADDR or a cycle budget of MAX_CYC expires,
// then holds done (and timeout on a fault) until the request is withdrawn.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high block reset
//   bus   : run_sequencer_if slave modport (req/prog_ctr in, status out)
// All outputs are flops loaded from the next-state decode.
module run_sequencer #(
   parameter int unsigned PW        = 9,
   parameter int unsigned HALT_ADDR = 285,
   parameter int unsigned RST_CYC   = 2,
   parameter logic [15:0] MAX_CYC   = 16'd50000
) (
   input logic            clk,
   input logic            reset,
   run_sequencer_if.slave bus
);

   localparam int unsigned HOLD_W = 4;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_RUN   = 3'd2,
      S_HALT  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               core_reset_q, core_reset_d;
   logic               core_run_q, core_run_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;

   // Next-state, counters and registered-output decode
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               state_d = S_RST;
               hold_d  = '0;
               cnt_d   = '0;
            end
         end
         S_RST: begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(RST_CYC - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Halt wins over a coincident budget expiry; no count on the halt edge.
            if (bus.prog_ctr == PW'(HALT_ADDR)) begin
               state_d = S_HALT;
            end else begin
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cnt_q == MAX_CYC - 16'd1) begin
                  state_d = S_FAULT;
               end
            end
         end
         S_HALT, S_FAULT: begin
            if (!bus.req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
      core_run_d   = (state_d == S_RUN);
      busy_d       = (state_d == S_RST) || (state_d == S_RUN);
      done_d       = (state_d == S_HALT) || (state_d == S_FAULT);
      timeout_d    = (state_d == S_FAULT);
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         cnt_q        <= '0;
         core_reset_q <= 1'b1;
         core_run_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         core_reset_q <= core_reset_d;
         core_run_q   <= core_run_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.core_reset = core_reset_q;
   assign bus.core_run   = core_run_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: one default instance (dut_a) and one
// with a 20-cycle budget (dut_b), driven from the same stimulus.
module tb_run_sequencer;

   localparam int unsigned PW   = 9;
   localparam int unsigned HALT = 285;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [PW-1:0] prog;
   int            n_checks = 0;
   int            n_errors = 0;

   run_sequencer_if #(.PW(PW)) bus_a ();
   run_sequencer_if #(.PW(PW)) bus_b ();

   assign bus_a.req      = req;
   assign bus_a.prog_ctr = prog;
   assign bus_b.req      = req;
   assign bus_b.prog_ctr = prog;

   run_sequencer #(.PW(PW), .HALT_ADDR(HALT), .RST_CYC(2), .MAX_CYC(16'd50000)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   run_sequencer #(.PW(PW), .HALT_ADDR(HALT), .RST_CYC(2), .MAX_CYC(16'd20)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_b(input string tag, input int exp_cnt);
      chk({tag, ".core_reset"}, 32'(bus_b.core_reset), 32'd1);
      chk({tag, ".core_run"},   32'(bus_b.core_run),   32'd0);
      chk({tag, ".busy"},       32'(bus_b.busy),       32'd0);
      chk({tag, ".done"},       32'(bus_b.done),       32'd0);
      chk({tag, ".timeout"},    32'(bus_b.timeout),    32'd0);
      chk({tag, ".cnt"},        32'(bus_b.cycle_cnt),  32'(exp_cnt));
   endtask

   // Start from IDLE, run on dut_b until halt on RUN cycle halt_k (0 = never)
   task automatic do_run(input string tag, input int halt_k, input bit toggle);
      req  = 1'b1;
      prog = PW'(HALT);            // must be ignored outside RUN
      tick();
      chk({tag, ".rst1.core_reset"}, 32'(bus_b.core_reset), 32'd1);
      chk({tag, ".rst1.busy"},       32'(bus_b.busy),       32'd1);
      chk({tag, ".rst1.cnt"},        32'(bus_b.cycle_cnt),  32'd0);
      tick();
      chk({tag, ".rst2.core_reset"}, 32'(bus_b.core_reset), 32'd1);
      chk({tag, ".rst2.core_run"},   32'(bus_b.core_run),   32'd0);
      tick();
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("%s.run%0d.core_run", tag, k), 32'(bus_b.core_run), 32'd1);
         chk($sformatf("%s.run%0d.core_reset", tag, k), 32'(bus_b.core_reset), 32'd0);
         chk($sformatf("%s.run%0d.cnt", tag, k), 32'(bus_b.cycle_cnt), 32'(k - 1));
         prog = (k == halt_k) ? PW'(HALT) : PW'(k);
         if (toggle) req = ~req;
         tick();
         if (k == halt_k) break;
      end
      chk({tag, ".end.done"},     32'(bus_b.done),      32'd1);
      chk({tag, ".end.busy"},     32'(bus_b.busy),      32'd0);
      chk({tag, ".end.core_run"}, 32'(bus_b.core_run),  32'd0);
      chk({tag, ".end.core_rst"}, 32'(bus_b.core_reset), 32'd0);
      if (halt_k >= 1 && halt_k <= 20) begin
         chk({tag, ".end.timeout"}, 32'(bus_b.timeout),   32'd0);
         chk({tag, ".end.cnt"},     32'(bus_b.cycle_cnt), 32'(halt_k - 1));
      end else begin
         chk({tag, ".end.timeout"}, 32'(bus_b.timeout),   32'd1);
         chk({tag, ".end.cnt"},     32'(bus_b.cycle_cnt), 32'd20);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 1'b0;
      prog  = '0;
      tick();
      chk_idle_b("reset", 0);
      chk("reset.a.core_reset", 32'(bus_a.core_reset), 32'd1);
      reset = 1'b0;
      tick();
      chk_idle_b("idle", 0);

      // Normal run: halt on 10th RUN cycle
      do_run("norm", 10, 1'b0);
      chk("norm.a.done", 32'(bus_a.done), 32'd1);
      chk("norm.a.cnt",  32'(bus_a.cycle_cnt), 32'd9);
      req = 1'b0;
      tick();
      chk_idle_b("norm.idle", 9);

      // Request toggling during RUN must not change anything
      do_run("tog", 10, 1'b1);
      req = 1'b0;
      tick();
      chk_idle_b("tog.idle", 9);

      // Sticky done with req held, then pulse low/high for a new run
      do_run("stky", 10, 1'b0);
      req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("stky.hold%0d.done", i), 32'(bus_b.done), 32'd1);
         chk($sformatf("stky.hold%0d.busy", i), 32'(bus_b.busy), 32'd0);
         chk($sformatf("stky.hold%0d.cnt", i),  32'(bus_b.cycle_cnt), 32'd9);
      end
      req = 1'b0;
      tick();
      chk_idle_b("stky.idle", 9);
      do_run("stky2", 5, 1'b0);
      req = 1'b0;
      tick();
      chk_idle_b("stky2.idle", 4);

      // Timeout on dut_b; dut_a has a larger budget and keeps running
      do_run("tmo", 0, 1'b0);
      chk("tmo.a.busy", 32'(bus_a.busy), 32'd1);
      chk("tmo.a.cnt",  32'(bus_a.cycle_cnt), 32'd20);
      req = 1'b1;
      tick();
      chk("tmo.sticky.timeout", 32'(bus_b.timeout), 32'd1);
      req = 1'b0;
      tick();
      chk_idle_b("tmo.idle", 20);

      // Halt and budget expiry on the same cycle: halt wins
      do_run("tie", 20, 1'b0);
      req = 1'b0;
      tick();
      chk_idle_b("tie.idle", 19);

      // Mid-run reset on the 5th RUN cycle, req kept high
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req   = 1'b1;
      prog  = '0;
      repeat (7) tick();
      chk("mid.run5.cnt",      32'(bus_b.cycle_cnt), 32'd4);
      chk("mid.run5.core_run", 32'(bus_b.core_run),  32'd1);
      reset = 1'b1;
      tick();
      chk_idle_b("mid.reset", 0);
      chk("mid.a.cnt", 32'(bus_a.cycle_cnt), 32'd0);
      reset = 1'b0;
      tick();
      chk("mid.rst.busy",       32'(bus_b.busy),       32'd1);
      chk("mid.rst.core_reset", 32'(bus_b.core_reset), 32'd1);
      tick();
      tick();
      chk("mid.run1.core_run", 32'(bus_b.core_run), 32'd1);
      prog = PW'(HALT);
      tick();
      chk("mid.halt1.done", 32'(bus_b.done),      32'd1);
      chk("mid.halt1.cnt",  32'(bus_b.cycle_cnt), 32'd0);
      req = 1'b0;
      tick();
      chk_idle_b("mid.idle", 0);

      // Reset while in HALT
      do_run("hrst", 4, 1'b0);
      reset = 1'b1;
      req   = 1'b1;
      tick();
      chk_idle_b("hrst.reset", 0);
      reset = 1'b0;
      tick();
      chk("hrst.rst.busy", 32'(bus_b.busy), 32'd1);
      chk("hrst.rst.cnt",  32'(bus_b.cycle_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
